row_col_address_buffer: RTL and testbench

Parametrised multi-bank row/column address buffer for the DRAM-style memory path. It latches a multiplexed address bus on RAS (row) and CAS (column), keeps one open row per bank, and enforces a RAS-to-CAS delay. On each legal CAS it emits a registered full {bank,row,col} address with a one-cycle valid pulse. Illegal command sequences are flagged and have no effect on state.

---
 rtl/row_col_address_buffer_pkg.sv | 43 ++++
 rtl/row_col_address_buffer_if.sv | 47 ++++
 rtl/row_col_address_buffer_bank_row_tracker.sv | 86 ++++++++
 rtl/row_col_address_buffer.sv | 155 +++++++++++++++
 tb/tb_row_col_address_buffer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/row_col_address_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : row_col_address_buffer_pkg
// Purpose  : Shared types and helpers for the row/column address buffer:
//            bank state encoding, command encoding, bank-index width helper.
// Revision : 1.0 - initial release
// ============================================================================
package row_col_address_buffer_pkg;

  // Per-bank lifecycle: closed, waiting out tRCD, open for column access
  typedef enum logic [1:0] {
    BANK_IDLE       = 2'd0,
    BANK_ACTIVATING = 2'd1,
    BANK_ACTIVE     = 2'd2
  } bank_state_e;

  // Decoded strobe combination for one cycle
  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_RAS   = 3'd1,
    CMD_CAS   = 3'd2,
    CMD_PRE   = 3'd3,
    CMD_MULTI = 3'd4
  } cmd_e;

  // Bank index width; a single bank still gets a 1-bit select
  function automatic int bank_width(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

  // Any combination of more than one strobe is reported as CMD_MULTI
  function automatic cmd_e decode_cmd(input logic ras, input logic cas, input logic pre);
    case ({ras, cas, pre})
      3'b000:  return CMD_NOP;
      3'b100:  return CMD_RAS;
      3'b010:  return CMD_CAS;
      3'b001:  return CMD_PRE;
      default: return CMD_MULTI;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/row_col_address_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : row_col_address_buffer_if
// Purpose  : Command bus (strobes, bank select, multiplexed address) and
//            result bus (latched address, status pulses) of the buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface row_col_address_buffer_if #(
  parameter int ROW_W = 5,
  parameter int COL_W = 5,
  parameter int BANKS = 4
);
  import row_col_address_buffer_pkg::*;

  localparam int BANK_W = bank_width(BANKS);
  localparam int ADDR_W = (ROW_W > COL_W) ? ROW_W : COL_W;

  // Command side
  logic              ras;
  logic              cas;
  logic              pre;
  logic [BANK_W-1:0] bank_sel;
  logic [ADDR_W-1:0] addr_in;

  // Result side
  logic [ROW_W-1:0]  row_address_output;
  logic [COL_W-1:0]  col_address_output;
  logic [BANK_W-1:0] bank_out;
  logic              addr_valid;
  logic [BANKS-1:0]  row_open;
  logic              row_hit;
  logic              cmd_err;

  modport master (
    output ras, cas, pre, bank_sel, addr_in,
    input  row_address_output, col_address_output, bank_out,
    input  addr_valid, row_open, row_hit, cmd_err
  );

  modport slave (
    input  ras, cas, pre, bank_sel, addr_in,
    output row_address_output, col_address_output, bank_out,
    output addr_valid, row_open, row_hit, cmd_err
  );

endinterface
`default_nettype wire

// File: rtl/row_col_address_buffer_bank_row_tracker.sv
`default_nettype none
// ============================================================================
// Module   : bank_row_tracker
// Purpose  : State of one bank: IDLE/ACTIVATING/ACTIVE FSM, the open row and
//            the RAS-to-CAS delay counter. The parent only asserts i_act on
//            an IDLE bank, so this block does not re-check legality.
// Revision : 1.0 - initial release
// ============================================================================
module bank_row_tracker #(
  parameter int ROW_W = 5,
  parameter int T_RCD = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_act,
  input  wire logic             i_pre,
  input  wire logic [ROW_W-1:0] i_row,
  output logic                  o_active,
  output logic                  o_activating,
  output logic                  o_row_match,
  output logic [ROW_W-1:0]      o_row
);
  import row_col_address_buffer_pkg::*;

  localparam int CNT_W = (T_RCD > 1) ? $clog2(T_RCD) : 1;

  localparam logic [1:0] c_ST_IDLE       = BANK_IDLE;
  localparam logic [1:0] c_ST_ACTIVATING = BANK_ACTIVATING;
  localparam logic [1:0] c_ST_ACTIVE     = BANK_ACTIVE;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [ROW_W-1:0] r_row;

  // Bank FSM, open-row latch and tRCD countdown
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= '0;
      r_row   <= '0;
    end else if (i_pre) begin
      // Row value is left as-is; row match is gated by ACTIVE so it is harmless
      r_state <= c_ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (i_act) begin
            r_row <= i_row;
            if (T_RCD == 1) begin
              r_state <= c_ST_ACTIVE;
              r_cnt   <= '0;
            end else begin
              r_state <= c_ST_ACTIVATING;
              r_cnt   <= CNT_W'(T_RCD - 1);
            end
          end
        end
        c_ST_ACTIVATING: begin
          // Opening on the edge where the count would reach zero makes a CAS
          // sampled T_RCD edges after the RAS the first legal one
          if (r_cnt == CNT_W'(1)) begin
            r_state <= c_ST_ACTIVE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        c_ST_ACTIVE: begin
          r_state <= c_ST_ACTIVE;
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_active     = (r_state == c_ST_ACTIVE);
  assign o_activating = (r_state == c_ST_ACTIVATING);
  assign o_row_match  = o_active && (r_row == i_row);
  assign o_row        = r_row;

endmodule
`default_nettype wire

// File: rtl/row_col_address_buffer.sv
`default_nettype none
// ============================================================================
// Module   : row_col_address_buffer
// Purpose  : Multi-bank row/column address buffer. Decodes RAS/CAS/PRE,
//            tracks one open row per bank and emits a registered
//            {bank,row,col} address with a one-cycle valid pulse per CAS.
// Revision : 1.0 - initial release
// ============================================================================
module row_col_address_buffer #(
  parameter int ROW_W = 5,
  parameter int COL_W = 5,
  parameter int BANKS = 4,
  parameter int T_RCD = 2
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  row_col_address_buffer_if.slave     bus
);
  import row_col_address_buffer_pkg::*;

  localparam int BANK_W = bank_width(BANKS);

  cmd_e              w_cmd;
  logic              w_bank_ok;
  logic [BANK_W-1:0] w_bank_idx;
  logic [ROW_W-1:0]  w_row_in;
  logic [COL_W-1:0]  w_col_in;

  logic [BANKS-1:0]  w_active;
  logic [BANKS-1:0]  w_activating;
  logic [BANKS-1:0]  w_row_match;
  logic [ROW_W-1:0]  w_rows [BANKS];

  logic              w_sel_active;
  logic              w_sel_activating;
  logic              w_sel_match;
  logic [ROW_W-1:0]  w_sel_row;

  logic              w_act_en;
  logic              w_pre_en;
  logic              w_cas_ok;
  logic              w_hit;
  logic              w_err;

  logic [ROW_W-1:0]  r_row_out;
  logic [COL_W-1:0]  r_col_out;
  logic [BANK_W-1:0] r_bank_out;
  logic              r_valid;
  logic              r_hit;
  logic              r_err;

  assign w_cmd    = decode_cmd(bus.ras, bus.cas, bus.pre);
  assign w_row_in = bus.addr_in[ROW_W-1:0];
  assign w_col_in = bus.addr_in[COL_W-1:0];

  // Every encodable select is a real bank when BANKS is a power of two
  if (BANKS == (1 << BANK_W)) begin : g_bank_full
    assign w_bank_ok = 1'b1;
  end else begin : g_bank_partial
    assign w_bank_ok = (bus.bank_sel < BANK_W'(BANKS));
  end

  // Out-of-range selects are steered to bank 0 so the muxes stay in range
  assign w_bank_idx = w_bank_ok ? bus.bank_sel : '0;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    bank_row_tracker #(
      .ROW_W (ROW_W),
      .T_RCD (T_RCD)
    ) u_tracker (
      .clk          (clk),
      .rst          (rst),
      .i_act        (w_act_en && (w_bank_idx == BANK_W'(b))),
      .i_pre        (w_pre_en && (w_bank_idx == BANK_W'(b))),
      .i_row        (w_row_in),
      .o_active     (w_active[b]),
      .o_activating (w_activating[b]),
      .o_row_match  (w_row_match[b]),
      .o_row        (w_rows[b])
    );
  end

  assign w_sel_active     = w_active[w_bank_idx];
  assign w_sel_activating = w_activating[w_bank_idx];
  assign w_sel_match      = w_row_match[w_bank_idx];
  assign w_sel_row        = w_rows[w_bank_idx];

  // Command legality check against the selected bank's state
  always_comb begin
    w_act_en = 1'b0;
    w_pre_en = 1'b0;
    w_cas_ok = 1'b0;
    w_hit    = 1'b0;
    w_err    = 1'b0;
    case (w_cmd)
      CMD_RAS: begin
        if (!w_bank_ok) begin
          w_err = 1'b1;
        end else if (w_sel_active) begin
          // Re-activating the open row is harmless; a different row needs PRE
          if (w_sel_match) w_hit = 1'b1;
          else             w_err = 1'b1;
        end else if (w_sel_activating) begin
          w_err = 1'b1;
        end else begin
          w_act_en = 1'b1;
        end
      end
      CMD_CAS: begin
        if (w_bank_ok && w_sel_active) w_cas_ok = 1'b1;
        else                           w_err    = 1'b1;
      end
      CMD_PRE: begin
        if (w_bank_ok) w_pre_en = 1'b1;
        else           w_err    = 1'b1;
      end
      CMD_MULTI: begin
        w_err = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Output registers: address held between accepted CAS, status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_out  <= '0;
      r_col_out  <= '0;
      r_bank_out <= '0;
      r_valid    <= 1'b0;
      r_hit      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_valid <= w_cas_ok;
      r_hit   <= w_hit;
      r_err   <= w_err;
      if (w_cas_ok) begin
        r_row_out  <= w_sel_row;
        r_col_out  <= w_col_in;
        r_bank_out <= bus.bank_sel;
      end
    end
  end

  assign bus.row_address_output = r_row_out;
  assign bus.col_address_output = r_col_out;
  assign bus.bank_out           = r_bank_out;
  assign bus.addr_valid         = r_valid;
  assign bus.row_hit            = r_hit;
  assign bus.cmd_err            = r_err;
  assign bus.row_open           = w_active;

endmodule
`default_nettype wire

// File: tb/tb_row_col_address_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_row_col_address_buffer
// Purpose  : Directed self-checking bench for row_col_address_buffer
//            (ROW_W=5, COL_W=5, BANKS=4, T_RCD=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_row_col_address_buffer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  row_col_address_buffer_if #(.ROW_W(5), .COL_W(5), .BANKS(4)) bus ();

  row_col_address_buffer #(
    .ROW_W (5),
    .COL_W (5),
    .BANKS (4),
    .T_RCD (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Apply one command for one edge, then sample 1 time unit after the edge
  task automatic drive(input logic r, input logic c, input logic p,
                       input logic [1:0] b, input logic [4:0] a);
    bus.ras      = r;
    bus.cas      = c;
    bus.pre      = p;
    bus.bank_sel = b;
    bus.addr_in  = a;
    @(posedge clk);
    #1;
    bus.ras = 1'b0;
    bus.cas = 1'b0;
    bus.pre = 1'b0;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 5'd0);
  endtask

  task automatic chk_pulses(input string tag, input logic v, input logic h, input logic e);
    check({tag, ".valid"}, 32'(bus.addr_valid), 32'(v));
    check({tag, ".hit"},   32'(bus.row_hit),    32'(h));
    check({tag, ".err"},   32'(bus.cmd_err),    32'(e));
  endtask

  task automatic chk_addr(input string tag, input logic [1:0] b, input logic [4:0] r,
                          input logic [4:0] c);
    check({tag, ".bank"}, 32'(bus.bank_out),           32'(b));
    check({tag, ".row"},  32'(bus.row_address_output), 32'(r));
    check({tag, ".col"},  32'(bus.col_address_output), 32'(c));
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    // Reset with a RAS held on the bus: reset must win
    rst          = 1'b1;
    bus.ras      = 1'b1;
    bus.cas      = 1'b0;
    bus.pre      = 1'b0;
    bus.bank_sel = 2'd0;
    bus.addr_in  = 5'h0A;
    repeat (2) @(posedge clk);
    #1;
    chk_pulses("reset", 1'b0, 1'b0, 1'b0);
    chk_addr("reset", 2'd0, 5'h00, 5'h00);
    check("reset.row_open", 32'(bus.row_open), 32'h0);
    bus.ras = 1'b0;
    rst     = 1'b0;
    nop();
    check("reset.hold_open", 32'(bus.row_open), 32'h0);

    // Basic activate + access on bank 0
    drive(1'b1, 1'b0, 1'b0, 2'd0, 5'h0A);
    chk_pulses("ras0", 1'b0, 1'b0, 1'b0);
    check("ras0.activating", 32'(bus.row_open), 32'h0);
    nop();
    nop();
    check("ras0.open", 32'(bus.row_open), 32'h1);
    drive(1'b0, 1'b1, 1'b0, 2'd0, 5'h13);
    chk_pulses("cas0", 1'b1, 1'b0, 1'b0);
    chk_addr("cas0", 2'd0, 5'h0A, 5'h13);
    check("cas0.row_open", 32'(bus.row_open), 32'h1);
    nop();
    chk_pulses("cas0.after", 1'b0, 1'b0, 1'b0);
    chk_addr("cas0.hold", 2'd0, 5'h0A, 5'h13);

    // tRCD enforcement on bank 1
    drive(1'b1, 1'b0, 1'b0, 2'd1, 5'h05);
    drive(1'b0, 1'b1, 1'b0, 2'd1, 5'h07);
    chk_pulses("rcd.early", 1'b0, 1'b0, 1'b1);
    chk_addr("rcd.early_hold", 2'd0, 5'h0A, 5'h13);
    drive(1'b0, 1'b1, 1'b0, 2'd1, 5'h07);
    chk_pulses("rcd.ok", 1'b1, 1'b0, 1'b0);
    chk_addr("rcd.ok", 2'd1, 5'h05, 5'h07);
    check("rcd.row_open", 32'(bus.row_open), 32'h3);

    // Row hit, row conflict, precharge and re-activate on bank 0
    drive(1'b1, 1'b0, 1'b0, 2'd0, 5'h0A);
    chk_pulses("hit", 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 5'h0B);
    chk_pulses("conflict", 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 2'd0, 5'h01);
    chk_pulses("conflict.cas", 1'b1, 1'b0, 1'b0);
    chk_addr("conflict.row_kept", 2'd0, 5'h0A, 5'h01);
    drive(1'b0, 1'b0, 1'b1, 2'd0, 5'h00);
    chk_pulses("pre0", 1'b0, 1'b0, 1'b0);
    check("pre0.row_open", 32'(bus.row_open), 32'h2);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 5'h0B);
    chk_pulses("reras0", 1'b0, 1'b0, 1'b0);
    nop();
    drive(1'b0, 1'b1, 1'b0, 2'd0, 5'h02);
    chk_pulses("reras0.cas", 1'b1, 1'b0, 1'b0);
    chk_addr("reras0.cas", 2'd0, 5'h0B, 5'h02);

    // Illegal combinations and idle-bank commands
    drive(1'b1, 1'b1, 1'b0, 2'd0, 5'h0C);
    chk_pulses("multi", 1'b0, 1'b0, 1'b1);
    chk_addr("multi.hold", 2'd0, 5'h0B, 5'h02);
    drive(1'b0, 1'b1, 1'b0, 2'd0, 5'h03);
    chk_addr("multi.nochange", 2'd0, 5'h0B, 5'h03);
    drive(1'b0, 1'b1, 1'b0, 2'd2, 5'h04);
    chk_pulses("cas_idle2", 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 2'd3, 5'h00);
    chk_pulses("pre_idle3", 1'b0, 1'b0, 1'b0);
    check("pre_idle3.row_open", 32'(bus.row_open), 32'h3);

    // All four banks open, interleaved back-to-back CAS
    drive(1'b1, 1'b0, 1'b0, 2'd2, 5'h12);
    drive(1'b1, 1'b0, 1'b0, 2'd3, 5'h1C);
    nop();
    check("all.row_open", 32'(bus.row_open), 32'hF);
    drive(1'b0, 1'b1, 1'b0, 2'd0, 5'h10);
    chk_pulses("b2b0", 1'b1, 1'b0, 1'b0);
    chk_addr("b2b0", 2'd0, 5'h0B, 5'h10);
    drive(1'b0, 1'b1, 1'b0, 2'd1, 5'h11);
    chk_pulses("b2b1", 1'b1, 1'b0, 1'b0);
    chk_addr("b2b1", 2'd1, 5'h05, 5'h11);
    drive(1'b0, 1'b1, 1'b0, 2'd2, 5'h12);
    chk_pulses("b2b2", 1'b1, 1'b0, 1'b0);
    chk_addr("b2b2", 2'd2, 5'h12, 5'h12);
    drive(1'b0, 1'b1, 1'b0, 2'd3, 5'h13);
    chk_pulses("b2b3", 1'b1, 1'b0, 1'b0);
    chk_addr("b2b3", 2'd3, 5'h1C, 5'h13);
    nop();
    chk_pulses("b2b.end", 1'b0, 1'b0, 1'b0);

    // Reset while bank 0 is activating and a CAS is on the bus
    drive(1'b0, 1'b0, 1'b1, 2'd0, 5'h00);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 5'h04);
    check("rst_mid.activating", 32'(bus.row_open), 32'hE);
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 2'd0, 5'h05);
    chk_pulses("rst_mid", 1'b0, 1'b0, 1'b0);
    chk_addr("rst_mid", 2'd0, 5'h00, 5'h00);
    check("rst_mid.row_open", 32'(bus.row_open), 32'h0);
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 2'd0, 5'h05);
    chk_pulses("rst_mid.cas", 1'b0, 1'b0, 1'b1);
    chk_addr("rst_mid.cas_hold", 2'd0, 5'h00, 5'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
